// File: rtl/sdram_read_streamer_if.sv
// Signal bundle between the read streamer, its job client, EasySDRAM and the word consumer.
// master = streamer side, slave = environment side.
interface sdram_read_streamer_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [24:0]      baseAddr;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             done;
    logic             addrErr;
    logic             write;
    logic             full;
    logic             isWrite;
    logic [24:0]      address;
    logic [1:0]       writeMask;
    logic [15:0]      writeData;
    logic             keepOpen;
    logic             readValid;
    logic [24:0]      raddr;
    logic [15:0]      rdata;
    logic             outValid;
    logic [15:0]      outData;
    logic             outReady;

    modport master (
        input  start, baseAddr, length, full, readValid, raddr, rdata, outReady,
        output busy, done, addrErr, write, isWrite, address, writeMask, writeData,
               keepOpen, outValid, outData
    );

    modport slave (
        output start, baseAddr, length, full, readValid, raddr, rdata, outReady,
        input  busy, done, addrErr, write, isWrite, address, writeMask, writeData,
               keepOpen, outValid, outData
    );
endinterface

// File: rtl/sdram_read_streamer.sv
// Issues a run of EasySDRAM reads for a (base, length) job and streams the readouts out through an
// FWFT buffer. Credits keep in-flight reads plus buffered words within DEPTH, so no readout is lost.
module sdram_read_streamer #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst,
    sdram_read_streamer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t           r_state;
    logic [24:0]      r_issueAddr;
    logic [24:0]      r_expAddr;
    logic [LEN_W-1:0] r_issueLeft;
    logic [LEN_W-1:0] r_recvLeft;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    r_bufCount;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [15:0]      r_mem [DEPTH];
    logic             r_busy;
    logic             r_done;
    logic             r_addrErr;

    logic [CW-1:0]    w_credits;
    logic             w_push;
    logic             w_rdAccept;
    logic             w_pop;

    // A slot is committed from the moment a read is pushed until its word leaves the buffer.
    assign w_credits  = CW'(DEPTH) - r_inflight - r_bufCount;
    assign w_push     = (r_state == ISSUE) & ~bus.full & (r_issueLeft != '0) & (w_credits != '0);
    assign w_rdAccept = bus.readValid & (r_inflight != '0);
    assign w_pop      = (r_bufCount != '0) & bus.outReady;

    assign bus.write     = w_push;
    assign bus.isWrite   = 1'b0;
    assign bus.address   = r_issueAddr;
    assign bus.writeMask = 2'b00;
    assign bus.writeData = 16'h0000;
    assign bus.keepOpen  = (r_state == ISSUE);
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.addrErr   = r_addrErr;
    assign bus.outValid  = (r_bufCount != '0);
    assign bus.outData   = r_mem[r_rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_bufCount <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_push) - CW'(w_rdAccept);
            r_bufCount <= r_bufCount + CW'(w_rdAccept) - CW'(w_pop);
            if (w_rdAccept) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)      r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rdAccept) r_mem[r_wrPtr] <= bus.rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addrErr   <= 1'b0;
            r_issueAddr <= '0;
            r_expAddr   <= '0;
            r_issueLeft <= '0;
            r_recvLeft  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_issueAddr <= bus.baseAddr;
                        r_expAddr   <= bus.baseAddr;
                        r_issueLeft <= bus.length;
                        r_recvLeft  <= bus.length;
                        r_addrErr   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (bus.length != '0) ? ISSUE : FINISH;
                    end
                end
                ISSUE: begin
                    if (w_push) begin
                        r_issueAddr <= r_issueAddr + 25'd1;
                        r_issueLeft <= r_issueLeft - 1'b1;
                        if (r_issueLeft == LEN_W'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_recvLeft == '0 && r_bufCount == '0) r_state <= FINISH;
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Readouts with nothing outstanding are stray (e.g. left over from before a reset).
            if (bus.readValid) begin
                if (r_inflight == '0) begin
                    r_addrErr <= 1'b1;
                end else begin
                    r_expAddr  <= r_expAddr + 25'd1;
                    r_recvLeft <= r_recvLeft - 1'b1;
                    if (bus.raddr != r_expAddr) r_addrErr <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_read_streamer.sv
// Directed job sequence with a randomized EasySDRAM / consumer model; expected addresses and
// data come from job arithmetic (base + index) and a fixed address-to-data function.
module tb_sdram_read_streamer;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_read_streamer_if #(.LEN_W(LW)) bus();
    sdram_read_streamer #(.DEPTH(DEPTH), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [24:0] a;
        int          due;
    } rd_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          tmp_due;
    rd_t         rq[$];
    logic [24:0] job_base = '0;
    int          pushes = 0;
    int          pops = 0;
    int          dones = 0;
    bit          force_full = 1'b0;
    bit          rand_full = 1'b0;
    bit          inject = 1'b0;
    bit          corrupt = 1'b0;
    int          ready_mode = 1;

    function automatic logic [15:0] dfun(input logic [24:0] a);
        return a[15:0] ^ {a[24:16], a[6:0]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // EasySDRAM + consumer model: in-order readouts after a random latency, one per cycle.
    always @(negedge clk) begin
        cyc++;
        bus.readValid = 1'b0;
        bus.raddr     = '0;
        bus.rdata     = '0;
        if (inject) begin
            bus.readValid = 1'b1;
            bus.raddr     = 25'h0000123;
            bus.rdata     = 16'hDEAD;
            inject        = 1'b0;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            bus.readValid = 1'b1;
            bus.raddr     = rq[0].a ^ (corrupt ? 25'd1 : 25'd0);
            bus.rdata     = dfun(rq[0].a);
            corrupt       = 1'b0;
            void'(rq.pop_front());
        end
        bus.full     = force_full | (rand_full && ($urandom_range(0, 3) == 0));
        bus.outReady = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
        #1;
        if (rst) begin
            rq.delete();
            last_due = 0;
        end else begin
            if (bus.write) begin
                chk("no_push_when_full", 32'(bus.full), 32'd0);
                chk("issue_addr", 32'(bus.address), 32'(25'(job_base + 25'(pushes))));
                tmp_due = cyc + int'($urandom_range(2, 6));
                if (tmp_due <= last_due) tmp_due = last_due + 1;
                last_due = tmp_due;
                rq.push_back('{bus.address, tmp_due});
                pushes++;
                chk("outstanding_le_depth", 32'(pushes - pops <= DEPTH), 32'd1);
            end
            if (bus.outValid && bus.outReady) begin
                chk("stream_data", 32'(bus.outData), 32'(dfun(25'(job_base + 25'(pops)))));
                pops++;
            end
            if (bus.done) begin
                dones++;
                chk("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic start_job(input logic [24:0] base, input int len);
        @(negedge clk);
        job_base     = base;
        pushes       = 0;
        pops         = 0;
        dones        = 0;
        bus.start    = 1'b1;
        bus.baseAddr = base;
        bus.length   = LW'(len);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (dones == 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("done_seen", 32'(dones != 0), 32'd1);
    endtask

    task automatic check_job(input int len, input logic err);
        chk("push_count", 32'(pushes), 32'(len));
        chk("pop_count", 32'(pops), 32'(len));
        chk("done_once", 32'(dones), 32'd1);
        chk("addr_err", 32'(bus.addrErr), 32'(err));
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int p;
        int n;
        bus.start    = 1'b0;
        bus.baseAddr = '0;
        bus.length   = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addrErr", 32'(bus.addrErr), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_keepOpen", 32'(bus.keepOpen), 32'd0);
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // basic job, consumer always ready
        ready_mode = 1;
        start_job(25'h0000000, 8);
        wait_done(300);
        check_job(8, 1'b0);
        chk("const_isWrite", 32'(bus.isWrite), 32'd0);
        chk("const_writeMask", 32'(bus.writeMask), 32'd0);

        // stalled consumer: issue stops at DEPTH outstanding words
        ready_mode = 0;
        start_job(25'h0001000, 40);
        repeat (60) @(negedge clk);
        #2;
        chk("credit_stall_pushes", 32'(pushes), 32'(DEPTH));
        chk("credit_stall_write", 32'(bus.write), 32'd0);
        chk("credit_stall_keepOpen", 32'(bus.keepOpen), 32'd1);
        chk("credit_stall_outValid", 32'(bus.outValid), 32'd1);
        ready_mode = 1;
        wait_done(1000);
        check_job(40, 1'b0);

        // address wraps past the top of the 25-bit space
        start_job(25'h1FFFFFE, 4);
        wait_done(300);
        check_job(4, 1'b0);

        // command FIFO full held for 50 cycles mid-job
        ready_mode = 2;
        start_job(25'h002ABCD, 60);
        n = 0;
        while (pushes < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        force_full = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        p = pushes;
        repeat (48) @(negedge clk);
        #2;
        chk("full_hold_no_push", 32'(pushes), 32'(p));
        force_full = 1'b0;
        wait_done(2000);
        check_job(60, 1'b0);

        // zero-length job: done two cycles after start, no commands
        start_job(25'h0000500, 0);
        #2;
        chk("len0_busy", 32'(bus.busy), 32'd1);
        chk("len0_done_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        #2;
        chk("len0_done", 32'(bus.done), 32'd1);
        chk("len0_busy_low", 32'(bus.busy), 32'd0);
        chk("len0_pushes", 32'(pushes), 32'd0);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("stray_addrErr", 32'(bus.addrErr), 32'd1);
        chk("stray_discarded", 32'(bus.outValid), 32'd0);

        // wrong readout address: flagged, data still streamed
        ready_mode = 1;
        start_job(25'h0000777, 6);
        chk("start_clears_addrErr", 32'(bus.addrErr), 32'd0);
        corrupt = 1'b1;
        wait_done(300);
        check_job(6, 1'b1);

        // reset mid-issue with reads outstanding
        ready_mode = 0;
        start_job(25'h0003000, 40);
        n = 0;
        while (pushes < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #2;
        chk("abort_write", 32'(bus.write), 32'd0);
        chk("abort_keepOpen", 32'(bus.keepOpen), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_outValid", 32'(bus.outValid), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        start_job(25'h0004000, 12);
        wait_done(300);
        check_job(12, 1'b0);

        // random jobs with random FIFO-full and consumer backpressure
        rand_full  = 1'b1;
        ready_mode = 2;
        for (int j = 0; j < 5; j++) begin
            int len;
            len = int'($urandom_range(1, 50));
            start_job(25'($urandom), len);
            wait_done(3000);
            check_job(len, 1'b0);
        end
        rand_full = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
